// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer pair: default word width,
// FSM state encoding and a counter-sizing helper.
package serdes_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bits needed to count 0..value-1; used to size the bit counter.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake plus serial stream qualifiers between a word producer and
// the serializer.
interface piso_serializer_if
    import serdes_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             frame_last;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  frame_start,
        input  frame_last
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output serial_out,
        output serial_valid,
        output frame_start,
        output frame_last
    );

endinterface

// File: rtl/piso_bit_counter.sv
// WIDTH-modulo bit position counter with clear, increment and terminal count.
// Shared with the SIPO word-framing logic.
module piso_bit_counter
    import serdes_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      inc,
    output logic [clog2(WIDTH)-1:0]   cnt,
    output logic                      tc
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Clear has priority so a reload at terminal count restarts at zero
    // instead of wrapping through the increment path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter: accepts a word over valid/ready and emits
// it one bit per clock with frame qualifiers, back-to-back without bubbles.
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    piso_serializer_if.slave     bus
);

    localparam int CNT_W = clog2(WIDTH);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shifted;
    logic [CNT_W-1:0]   bit_cnt;
    logic               tc;
    logic               ready;
    logic               accept;
    logic               cnt_clear;
    logic               cnt_inc;
    logic               head_bit;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .cnt   (bit_cnt),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ready opens in IDLE and on the last bit of a frame, so a waiting word
    // is picked up on the edge that would otherwise end the frame.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.load_valid) begin
                    next_state = ST_SHIFT;
                    cnt_clear  = 1'b1;
                end
            end
            ST_SHIFT: begin
                cnt_inc = 1'b1;
                if (tc) begin
                    ready     = 1'b1;
                    cnt_clear = 1'b1;
                    if (!bus.load_valid) begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign accept = bus.load_valid && ready;

    always_comb begin
        shifted  = '0;
        head_bit = 1'b0;
        if (MSB_FIRST) begin
            shifted  = {shreg[WIDTH-2:0], 1'b0};
            head_bit = shreg[WIDTH-1];
        end else begin
            shifted  = {1'b0, shreg[WIDTH-1:1]};
            head_bit = shreg[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= bus.load_data;
        end else if (state == ST_SHIFT) begin
            shreg <= shifted;
        end
    end

    assign bus.load_ready   = ready;
    assign bus.serial_valid = (state == ST_SHIFT);
    assign bus.serial_out   = (state == ST_SHIFT) ? head_bit : IDLE_LEVEL;
    assign bus.frame_start  = (state == ST_SHIFT) && (bit_cnt == '0);
    assign bus.frame_last   = (state == ST_SHIFT) && tc;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: two serializer configurations checked every cycle
// against a queue-of-pending-bits reference model and a behavioural SIPO.
module tb_piso_serializer;
    import serdes_pkg::*;

    typedef struct packed {
        logic       b;
        int         pos;
        logic [7:0] word;
    } slot_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    piso_serializer_if #(.WIDTH(8)) bus8 ();
    piso_serializer_if #(.WIDTH(4)) bus4 ();

    piso_serializer #(
        .WIDTH      (8),
        .MSB_FIRST  (1'b1),
        .IDLE_LEVEL (1'b0)
    ) dut8 (
        .clk (clk),
        .rst (rst_n),
        .bus (bus8.slave)
    );

    piso_serializer #(
        .WIDTH      (4),
        .MSB_FIRST  (1'b0),
        .IDLE_LEVEL (1'b1)
    ) dut4 (
        .clk (clk),
        .rst (rst_n),
        .bus (bus4.slave)
    );

    always #5 clk = ~clk;

    slot_t      q8[$];
    slot_t      q4[$];
    logic [7:0] sipo8 = '0;
    logic [3:0] sipo4 = '0;
    int         nAsserts = 0;
    int         nFails = 0;
    bit         acc8;
    bit         acc4;

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Front of each queue is the bit the DUT should be showing right now.
    task automatic checkOutput();
        logic v8, v4;
        v8 = (q8.size() > 0);
        v4 = (q4.size() > 0);
        checkBit("valid8", bus8.serial_valid, v8);
        checkBit("out8",   bus8.serial_out,   v8 ? q8[0].b : 1'b0);
        checkBit("start8", bus8.frame_start,  v8 && q8[0].pos == 0);
        checkBit("last8",  bus8.frame_last,   v8 && q8[0].pos == 7);
        checkBit("ready8", bus8.load_ready,   q8.size() <= 1);
        checkBit("valid4", bus4.serial_valid, v4);
        checkBit("out4",   bus4.serial_out,   v4 ? q4[0].b : 1'b1);
        checkBit("start4", bus4.frame_start,  v4 && q4[0].pos == 0);
        checkBit("last4",  bus4.frame_last,   v4 && q4[0].pos == 3);
        checkBit("ready4", bus4.load_ready,   q4.size() <= 1);
    endtask

    // One clock: decide acceptance from the model, advance the model and the
    // downstream SIPOs, then compare.
    task automatic applyStimulus();
        logic [7:0] d8;
        logic [3:0] d4;
        logic       ob8, ob4;
        slot_t      s;
        acc8 = bus8.load_valid && (q8.size() <= 1);
        acc4 = bus4.load_valid && (q4.size() <= 1);
        d8   = bus8.load_data;
        d4   = bus4.load_data;
        ob8  = bus8.serial_out;
        ob4  = bus4.serial_out;
        @(posedge clk);
        #1;
        sipo8 = {sipo8[6:0], ob8};
        sipo4 = {ob4, sipo4[3:1]};
        if (q8.size() > 0) begin
            s = q8.pop_front();
            if (s.pos == 7) checkWord("sipo8", sipo8, s.word);
        end
        if (q4.size() > 0) begin
            s = q4.pop_front();
            if (s.pos == 3) checkWord("sipo4", {4'h0, sipo4}, s.word);
        end
        if (acc8) begin
            for (int i = 0; i < 8; i++) q8.push_back('{d8[7-i], i, d8});
        end
        if (acc4) begin
            for (int i = 0; i < 4; i++) q4.push_back('{d4[i], i, {4'h0, d4}});
        end
        checkOutput();
    endtask

    // Called one time unit after an edge; the reset hits mid-cycle.
    task automatic doReset();
        bus8.load_valid = 1'b0;
        bus4.load_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        q8.delete();
        q4.delete();
        #1;
        checkBit("rst_out8",   bus8.serial_out,   1'b0);
        checkBit("rst_valid8", bus8.serial_valid, 1'b0);
        checkBit("rst_start8", bus8.frame_start,  1'b0);
        checkBit("rst_last8",  bus8.frame_last,   1'b0);
        checkBit("rst_out4",   bus4.serial_out,   1'b1);
        checkBit("rst_valid4", bus4.serial_valid, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic sendWord8(input logic [7:0] data);
        bit done;
        done = 1'b0;
        bus8.load_data  = data;
        bus8.load_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            applyStimulus();
            done = acc8;
        end
        bus8.load_valid = 1'b0;
        checkBit("accept8_timeout", done, 1'b1);
    endtask

    task automatic sendWord4(input logic [3:0] data);
        bit done;
        done = 1'b0;
        bus4.load_data  = data;
        bus4.load_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            applyStimulus();
            done = acc4;
        end
        bus4.load_valid = 1'b0;
        checkBit("accept4_timeout", done, 1'b1);
    endtask

    initial begin
        bus8.load_data  = '0;
        bus8.load_valid = 1'b0;
        bus4.load_data  = '0;
        bus4.load_valid = 1'b0;
        #1;
        doReset();

        $display("[TB] idle for 20 cycles");
        repeat (20) applyStimulus();

        $display("[TB] single word 8'hB3");
        sendWord8(8'hB3);
        repeat (10) applyStimulus();

        $display("[TB] back-to-back 8'hB3, 8'h5A");
        sendWord8(8'hB3);
        sendWord8(8'h5A);
        repeat (10) applyStimulus();

        $display("[TB] 8'hFF offered during 8'h0F frame");
        sendWord8(8'h0F);
        repeat (2) applyStimulus();
        sendWord8(8'hFF);
        repeat (10) applyStimulus();

        $display("[TB] reset during bit 4 of 8'hB3");
        sendWord8(8'hB3);
        repeat (3) applyStimulus();
        doReset();
        sendWord8(8'h81);
        repeat (10) applyStimulus();

        $display("[TB] LSB-first WIDTH=4 word 4'b0011");
        sendWord4(4'b0011);
        repeat (6) applyStimulus();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            bus8.load_valid = ($urandom_range(0, 3) != 0);
            bus8.load_data  = 8'($urandom);
            bus4.load_valid = ($urandom_range(0, 2) != 0);
            bus4.load_data  = 4'($urandom);
            applyStimulus();
        end
        bus8.load_valid = 1'b0;
        bus4.load_valid = 1'b0;
        repeat (12) applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out converter that sits directly upstream of the SIPO shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives one bit per clock on serial_out.
- Delivers words back-to-back with no bubble between frames, so a downstream SIPO clocked on the same clk reassembles each word after WIDTH cycles.
- Also drives frame qualifiers (serial_valid, frame_start, frame_last) so downstream logic can align word boundaries.

Parameters:
- WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- IDLE_LEVEL, 0, value driven on serial_out while no frame is active.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_data  input  WIDTH  word to serialize; sampled on the accept edge.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  serializer can accept a word this cycle.
- serial_out  output  1  serial bit stream.
- serial_valid  output  1  serial_out carries a frame bit this cycle.
- frame_start  output  1  high during the first bit of a frame.
- frame_last  output  1  high during the last bit of a frame.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE and bit_cnt to 0.
  - Shift register clears to 0.
  - serial_out = IDLE_LEVEL; serial_valid, frame_start and frame_last = 0.
  - load_ready = 1 once rst is deasserted.
- Reset mid-frame aborts the frame immediately; the partial word is discarded and is not resumed.
- Accept: a word is accepted on a rising edge where load_valid && load_ready. Holding load_valid while load_ready = 0 has no effect; the data is held off, not dropped.
- load_ready is combinational: (state == IDLE) || (state == SHIFT && bit_cnt == WIDTH-1).
- Latency: the first bit appears on serial_out in the cycle immediately after the accept edge. Each frame occupies exactly WIDTH consecutive cycles.
- State machine:
  - IDLE:
    - On accept, load the shift register, set bit_cnt = 0, go to SHIFT.
    - Otherwise stay in IDLE with serial_valid = 0.
  - SHIFT:
    - Each cycle, shift by one position toward the output end and increment bit_cnt.
    - At bit_cnt == WIDTH-1 with an accept: reload, set bit_cnt = 0, stay in SHIFT. This is the back-to-back case, with no idle cycle between frames.
    - At bit_cnt == WIDTH-1 without an accept: go to IDLE.
- Outputs are registered and derived from state:
  - serial_out = shreg[WIDTH-1] when MSB_FIRST = 1, else shreg[0].
  - serial_valid = (state == SHIFT).
  - frame_start = serial_valid && bit_cnt == 0.
  - frame_last = serial_valid && bit_cnt == WIDTH-1.
  - In IDLE, serial_out = IDLE_LEVEL.
- Width rules:
  - bit_cnt is $clog2(WIDTH) bits and wraps only through the reload path; it is never compared beyond WIDTH-1.
  - Vacated shift-register positions fill with 0.
- Downstream contract: the SIPO samples serial_out on every edge. After frame_last, the sampling edge presents the full word on its parallel_out.

Decomposition:
- Shared package serdes_pkg holds:
  - localparam DEFAULT_WIDTH = 8;
  - the state enum/localparams ST_IDLE = 1'b0 and ST_SHIFT = 1'b1;
  - a clog2 helper constant function for counter sizing.
- One natural sub-module: piso_bit_counter. It is a WIDTH-modulo counter with clear, increment and terminal-count output (tc = cnt == WIDTH-1), and is reused by the SIPO word-framing logic.
- The shift register and FSM stay in the top module.

Test Plan:
- Reset then load 8'hB3 with MSB_FIRST=1 -> serial_out = 1,0,1,1,0,0,1,1 in cycles 1..8 after the accept; frame_start in cycle 1, frame_last in cycle 8; a chained SIPO shows parallel_out = 8'hB3.
- load_valid held high with 8'hB3 then 8'h5A -> 16 contiguous serial_valid cycles; load_ready high only in cycle 8 of frame 1; stream = 10110011 01011010 with no gap.
- load_valid asserted with 8'hFF during bit 3 of an 8'h0F frame -> not accepted until bit 7; the 8'h0F frame is unaltered.
- rst pulled low during bit 4 of 8'hB3 -> serial_out = IDLE_LEVEL and serial_valid = 0 asynchronously; after release, load_ready = 1; a new word 8'h81 serializes cleanly.
- MSB_FIRST=0 with WIDTH=4, load 4'b0011 -> serial_out = 1,1,0,0; frame_last in cycle 4.
- Idle: no load_valid for 20 cycles after reset -> serial_out stays IDLE_LEVEL, serial_valid/frame_start/frame_last stay 0, load_ready stays 1.
